// File: rtl/store_narrower.sv
// Read-modify-write store narrower: merges a byte/halfword into a full memory word.
// Optional signed-truncation check enabled by macro STORE_NARROW_OVF_CHECK_EN.
module store_narrower #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic              trunc_ovf,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rd_valid,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      state_r;
    logic [1:0]  lane_r;
    logic        half_r;
    logic [15:0] wlo_r;
    logic        fault_s;
    logic        ovf_s;

    // Lane merge: only the addressed byte/halfword is replaced, the rest is kept from memory.
    function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [15:0] d,
                                               input logic [1:0] lane, input logic half);
        logic [31:0] w;
        w = old_w;
        if (half) begin
            if (lane[1]) w[31:16] = d;
            else         w[15:0]  = d;
        end else begin
            case (lane)
                2'd0:    w[7:0]   = d[7:0];
                2'd1:    w[15:8]  = d[7:0];
                2'd2:    w[23:16] = d[7:0];
                2'd3:    w[31:24] = d[7:0];
                default: w        = old_w;
            endcase
        end
        return w;
    endfunction

    // Alignment and size legality of the incoming request.
    always_comb begin
        fault_s = 1'b0;
        case (size)
            2'b00:   fault_s = 1'b0;
            2'b01:   fault_s = addr[0];
            2'b10:   fault_s = (addr[1:0] != 2'b00);
            default: fault_s = 1'b1;
        endcase
    end

`ifdef STORE_NARROW_OVF_CHECK_EN
    // The narrowed value is lossless only if the dropped bits are copies of its sign bit.
    function automatic logic ovf_check(input logic [1:0] sz, input logic [31:0] w);
        logic r;
        case (sz)
            2'b00:   r = !((&w[31:7]) || (~|w[31:7]));
            2'b01:   r = !((&w[31:15]) || (~|w[31:15]));
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign ovf_s = fault_s ? 1'b0 : ovf_check(size, wdata);
`else
    assign ovf_s = 1'b0;
`endif

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            trunc_ovf <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0000_0000;
            lane_r    <= 2'b00;
            half_r    <= 1'b0;
            wlo_r     <= 16'h0000;
        end else begin
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            done      <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        lane_r    <= addr[1:0];
                        half_r    <= (size == 2'b01);
                        wlo_r     <= wdata[15:0];
                        fault     <= fault_s;
                        trunc_ovf <= ovf_s;
                        busy      <= 1'b1;
                        if (fault_s) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else if (size == 2'b10) begin
                            state_r   <= WRITE;
                            mem_wr_en <= 1'b1;
                            mem_wdata <= wdata;
                        end else begin
                            state_r   <= RD_REQ;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                RD_REQ: state_r <= RD_WAIT;
                RD_WAIT: begin
                    if (mem_rd_valid) begin
                        state_r   <= WRITE;
                        mem_wr_en <= 1'b1;
                        mem_wdata <= merge_word(mem_rdata, wlo_r, lane_r, half_r);
                    end
                end
                WRITE: begin
                    state_r <= DONE;
                    done    <= 1'b1;
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_narrower.sv
// Randomized self-checking bench for store_narrower with a transaction-level reference model.
module tb_store_narrower;

    logic        clk = 1'b0;
    logic        rst, start, mem_rd_valid;
    logic [1:0]  size;
    logic [31:0] addr, wdata, mem_rdata;
    logic        busy, done, fault, trunc_ovf, mem_rd_en, mem_wr_en;
    logic [31:0] mem_addr, mem_wdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    store_narrower #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .size(size), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .fault(fault), .trunc_ovf(trunc_ovf),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .mem_rd_valid(mem_rd_valid), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_fault(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic bit model_ovf(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] w);
        int sw;
        sw = $signed(w);
`ifdef STORE_NARROW_OVF_CHECK_EN
        if (model_fault(sz, a)) return 1'b0;
        if (sz == 2'd0) return (sw < -128) || (sw > 127);
        if (sz == 2'd1) return (sw < -32768) || (sw > 32767);
        return 1'b0;
`else
        return (sw == 0) && (a == 32'd1) && (sz == 2'd3) && 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_merge(input logic [1:0] sz, input logic [31:0] a,
                                                input logic [31:0] w, input logic [31:0] rd);
        logic [7:0] b [4];
        int off;
        for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
        off = a % 4;
        b[off] = w[7:0];
        if (sz == 2'd1) b[off + 1] = w[15:8];
        return {b[3], b[2], b[1], b[0]};
    endfunction

    // One store transaction; memory answers lat cycles after the read request.
    task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] w,
                            input logic [31:0] rd, input int lat, input bit hold);
        int rd_cyc, wr_cyc, done_cyc, nrd, nwr, exp_rd, exp_wr, exp_done;
        logic [31:0] wr_data, wr_addr, exp_data;
        bit f, fault_seen, ovf_seen;
        rd_cyc = -1; wr_cyc = -1; done_cyc = -1; nrd = 0; nwr = 0;
        wr_data = 32'h0; wr_addr = 32'h0; fault_seen = 1'b0; ovf_seen = 1'b0;
        f = model_fault(sz, a);
        start = 1'b1; size = sz; addr = a; wdata = w; mem_rd_valid = 1'b0;
        for (int k = 1; k <= 60 && done_cyc < 0; k++) begin
            @(posedge clk); #1;
            if (!hold) start = 1'b0;
            else begin
                size = 2'($urandom_range(0, 3)); addr = $urandom; wdata = $urandom;
            end
            if (k == 1) check_eq("busy_after_start", busy, 1);
            check_eq("rd_wr_exclusive", mem_rd_en & mem_wr_en, 0);
            if (mem_rd_en) begin nrd++; if (rd_cyc < 0) rd_cyc = k; end
            if (mem_wr_en) begin nwr++; wr_cyc = k; wr_data = mem_wdata; wr_addr = mem_addr; end
            if (done) begin done_cyc = k; fault_seen = fault; ovf_seen = trunc_ovf; start = 1'b0; end
            mem_rd_valid = (k == 1) || (k == 1 + lat);
            mem_rdata = (k == 1 + lat) ? rd : $urandom;
        end
        if (f) begin
            exp_rd = 0; exp_wr = 0; exp_done = 1; exp_data = 32'h0;
        end else if (sz == 2'd2) begin
            exp_rd = 0; exp_wr = 1; exp_done = 2; exp_data = w;
        end else begin
            exp_rd = 1; exp_wr = lat + 2; exp_done = lat + 3; exp_data = model_merge(sz, a, w, rd);
        end
        check_eq("done_cycle", done_cyc, exp_done);
        check_eq("rd_en_count", nrd, exp_rd);
        check_eq("wr_en_count", nwr, (f ? 0 : 1));
        if (exp_rd == 1) check_eq("rd_en_cycle", rd_cyc, 1);
        if (!f) begin
            check_eq("wr_en_cycle", wr_cyc, exp_wr);
            check_eq("wr_data", wr_data, exp_data);
            check_eq("wr_addr", wr_addr, {a[31:2], 2'b00});
        end
        check_eq("fault", fault_seen, f);
        check_eq("trunc_ovf", ovf_seen, model_ovf(sz, a, w));
        check_eq("addr_at_done", mem_addr, {a[31:2], 2'b00});
        // Idle tail: no stray strobes, results held.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            mem_rd_valid = 1'b0;
            check_eq("tail_busy", busy, 0);
            check_eq("tail_done", done, 0);
            check_eq("tail_wr_en", mem_wr_en, 0);
            check_eq("tail_rd_en", mem_rd_en, 0);
            check_eq("tail_fault", fault, f);
            check_eq("tail_ovf", trunc_ovf, model_ovf(sz, a, w));
        end
    endtask

    // Halfword store abandoned by reset while waiting for read data.
    task automatic reset_in_rd_wait();
        int nwr, ndone;
        nwr = 0; ndone = 0;
        start = 1'b1; size = 2'd1; addr = 32'h0000_0402; wdata = 32'h0000_1234;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == 3) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        mem_rd_valid = 1'b1; mem_rdata = 32'hA5A5_A5A5;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            mem_rd_valid = 1'b0;
            if (mem_wr_en) nwr++;
            if (done) ndone++;
        end
        check_eq("rst_no_write", nwr, 0);
        check_eq("rst_no_done", ndone, 0);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a, w;
        logic [7:0]  b8;
        logic [15:0] h16;
        rst = 1'b1; start = 1'b0; size = 2'd0; addr = 32'h0; wdata = 32'h0;
        mem_rdata = 32'h0; mem_rd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_fault", fault, 0);
        check_eq("reset_ovf", trunc_ovf, 0);
        check_eq("reset_rd_en", mem_rd_en, 0);
        check_eq("reset_wr_en", mem_wr_en, 0);
        check_eq("reset_mem_addr", mem_addr, 32'h0);
        check_eq("reset_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_store(2'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1, 1'b0);
        do_store(2'd0, 32'h0000_0203, 32'h0000_0055, 32'h1122_3344, 3, 1'b0);
        do_store(2'd1, 32'h0000_0201, 32'h0000_BEEF, 32'h0, 1, 1'b0);
        do_store(2'd0, 32'h0000_0300, 32'hFFFF_FF80, 32'hCAFE_F00D, 2, 1'b0);
        do_store(2'd0, 32'h0000_0301, 32'h0000_0080, 32'hCAFE_F00D, 1, 1'b0);
        do_store(2'd1, 32'h0000_0302, 32'h0001_8000, 32'h0BAD_CAFE, 4, 1'b0);
        do_store(2'd3, 32'h0000_0304, 32'h0000_0001, 32'h0, 1, 1'b0);
        do_store(2'd2, 32'h0000_0502, 32'h1234_5678, 32'h0, 1, 1'b0);
        do_store(2'd2, 32'h0000_0600, 32'h0F0F_0F0F, 32'h0, 1, 1'b1);
        do_store(2'd0, 32'h0000_0601, 32'h0000_0077, 32'h8899_AABB, 2, 1'b1);
        reset_in_rd_wait();
        do_store(2'd2, 32'h0000_0700, 32'h7654_3210, 32'h0, 1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            sz = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            b8 = 8'($urandom); h16 = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       w = $urandom;
                1:       w = {{24{b8[7]}}, b8};
                default: w = {{16{h16[15]}}, h16};
            endcase
            do_store(sz, a, w, $urandom, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_narrower.md
STORE_NARROWER -- requirements
Module: store_narrower

Interface
REQ-001 Parameter: ADDR_W, default 32, byte-address width of addr and mem_addr.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  reset.
REQ-005 start  in  1  request strobe; sampled in IDLE only.
REQ-006 size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 addr  in  ADDR_W  byte address of the store.
REQ-008 wdata  in  32  register value to narrow and store.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 fault  out  1  misaligned or illegal size; valid with done, held until next accepted start.
REQ-012 trunc_ovf  out  1  narrowed value loses signed information; valid with done, held until next accepted start.
REQ-013 mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}, latched at start.
REQ-014 mem_rd_en  out  1  one-cycle read request.
REQ-015 mem_rdata  in  32  read data; valid only with mem_rd_valid.
REQ-016 mem_rd_valid  in  1  read data valid, arbitrary latency of 1 or more cycles after mem_rd_en.
REQ-017 mem_wr_en  out  1  one-cycle full-word write strobe.
REQ-018 mem_wdata  out  32  merged word, valid with mem_wr_en.

Function
REQ-019 FSM states: IDLE, RD_REQ, RD_WAIT, WRITE, DONE.
REQ-020 IDLE with start=1 latches addr, size and wdata, and computes fault and trunc_ovf.
REQ-021 Fault is set for size=11, for a halfword with addr[0]=1, and for a word with addr[1:0]!=0; a faulting request goes IDLE->DONE with no memory access.
REQ-022 A legal word request goes IDLE->WRITE with mem_wdata=wdata, so done asserts 2 cycles after start.
REQ-023 A legal byte or halfword request goes IDLE->RD_REQ, asserts mem_rd_en for 1 cycle, then moves to RD_WAIT.
REQ-024 In RD_WAIT, mem_rd_valid=1 captures the merged word and moves to WRITE; without mem_rd_valid the block waits indefinitely.
REQ-025 Merge is little-endian: a byte replaces lane addr[1:0], bits 8n+7:8n, with wdata[7:0]; a halfword replaces lane addr[1], bits 16n+15:16n, with wdata[15:0]; other bits come from mem_rdata.
REQ-026 WRITE asserts mem_wr_en for 1 cycle, then moves to DONE.
REQ-027 DONE asserts done for 1 cycle, then moves to IDLE; a new start is accepted on the following cycle at the earliest.
REQ-028 start while busy=1 is ignored, with no queuing.
REQ-029 mem_rd_valid outside RD_WAIT is ignored.
REQ-030 mem_rd_en and mem_wr_en are never high in the same cycle.

Reset
REQ-031 Reset sets the state to IDLE and sets busy, done, fault, trunc_ovf, mem_rd_en and mem_wr_en to 0, and mem_addr and mem_wdata to 0.
REQ-032 Reset in any state, including RD_WAIT or WRITE, abandons the request; no write is issued afterwards, and a late mem_rd_valid is ignored.

Configuration
REQ-033 Macro STORE_NARROW_OVF_CHECK_EN controls the overflow check.
REQ-034 With the macro defined:
- trunc_ovf=1 for a byte store when wdata[31:7] is not all-equal;
- trunc_ovf=1 for a halfword store when wdata[31:15] is not all-equal;
- trunc_ovf=0 for a word store or a faulting request.
REQ-035 Without the macro, trunc_ovf is tied to 0, the check logic is absent, and all other behaviour is unchanged.

Verification
REQ-036 Word store, addr=0x100, wdata=0xDEADBEEF -> no mem_rd_en; mem_wr_en at cycle 1 with mem_addr=0x100 and mem_wdata=0xDEADBEEF; done at cycle 2; fault=0.
REQ-037 Byte store, addr=0x203, wdata=0x00000055, mem_rdata=0x11223344 returned after 3 cycles -> mem_addr=0x200, mem_wdata=0x55223344.
REQ-038 Halfword store, addr=0x201 -> fault=1 and done at cycle 1; neither mem_rd_en nor mem_wr_en asserts.
REQ-039 Overflow check, macro defined: byte store with wdata=0xFFFFFF80 -> trunc_ovf=0; with wdata=0x00000080 -> trunc_ovf=1; same stimulus with macro undefined -> trunc_ovf=0.
REQ-040 Halfword store at addr=0x402 with rst pulsed during RD_WAIT -> busy=0 the next cycle; a later mem_rd_valid causes no mem_wr_en; a fresh word store then completes normally.
REQ-041 Second start asserted while busy -> ignored; exactly one mem_wr_en and one done result.
